// File: rtl/open_risc_v_soc.sv
// open_risc_v_soc: single-cycle RV32I-subset core with a combinational instruction ROM

module open_risc_v_rom #(
  parameter int ROM_DEPTH = 4096
) (
  input  logic [29:0] addr,
  output logic [31:0] data
);
  localparam int AW = ROM_DEPTH > 1 ? $clog2(ROM_DEPTH) : 1;
  logic [31:0] rom_mem [0:ROM_DEPTH-1];
  logic [AW-1:0] idx;
  // word index wraps modulo the ROM depth; contents come from a simulator preload
  assign idx = AW'(addr % 30'(ROM_DEPTH));
  assign data = rom_mem[idx];
endmodule

module open_risc_v_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];
  // clear everything on reset, otherwise single write port with x0 writes dropped
  always_ff @(posedge clk)
    if (!rst) regs <= '{default: '0};
    else if (we && waddr != 5'd0) regs[waddr] <= wdata;
  assign rd1 = ra1 == 5'd0 ? '0 : regs[ra1];
  assign rd2 = ra2 == 5'd0 ? '0 : regs[ra2];
endmodule

module open_risc_v #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [29:0] iaddr
);
  logic [31:0] pc, next_pc, rs1v, rs2v, wd, b, alu;
  logic [31:0] imm_i, imm_b, imm_j, imm_u;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  sh;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_opi, is_op;
  logic we, eq, lt, ltu, taken;

  assign op       = instr[6:0];
  assign f3       = instr[14:12];
  assign imm_i    = {{20{instr[31]}}, instr[31:20]};
  assign imm_b    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u    = {instr[31:12], 12'b0};
  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_br    = op == 7'b1100011;
  assign is_opi   = op == 7'b0010011;
  assign is_op    = op == 7'b0110011;
  // anything not listed (loads, stores, fence, system, unknown) leaves state alone
  assign we       = is_lui | is_auipc | is_jal | is_jalr | is_opi | is_op;

  assign b  = is_op ? rs2v : imm_i;
  assign sh = b[4:0];

  // shared ALU for register-register and register-immediate forms
  always_comb begin
    case (f3)
      3'b000:  alu = is_op && instr[30] ? rs1v - b : rs1v + b;
      3'b001:  alu = rs1v << sh;
      3'b010:  alu = {31'd0, $signed(rs1v) < $signed(b)};
      3'b011:  alu = {31'd0, rs1v < b};
      3'b100:  alu = rs1v ^ b;
      3'b101:  alu = instr[30] ? 32'($signed(rs1v) >>> sh) : rs1v >> sh;
      3'b110:  alu = rs1v | b;
      default: alu = rs1v & b;
    endcase
  end

  assign eq    = rs1v == rs2v;
  assign lt    = $signed(rs1v) < $signed(rs2v);
  assign ltu   = rs1v < rs2v;
  assign taken = is_br & (f3[2:1] == 2'b00 ? eq ^ f3[0] :
                          f3[2:1] == 2'b10 ? lt ^ f3[0] :
                          f3[2:1] == 2'b11 ? ltu ^ f3[0] : 1'b0);

  assign next_pc = taken   ? pc + imm_b :
                   is_jal  ? pc + imm_j :
                   is_jalr ? (rs1v + imm_i) & ~32'd1 : pc + 32'd4;
  assign wd = is_lui            ? imm_u :
              is_auipc          ? pc + imm_u :
              is_jal || is_jalr ? pc + 32'd4 : alu;
  assign iaddr = pc[31:2];

  // one instruction retires per edge; reset discards it and restarts fetch
  always_ff @(posedge clk)
    pc <= !rst ? RESET_PC : next_pc;

  open_risc_v_regs regs_inst (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (instr[11:7]),
    .wdata (wd),
    .ra1   (instr[19:15]),
    .ra2   (instr[24:20]),
    .rd1   (rs1v),
    .rd2   (rs2v)
  );
endmodule

module open_risc_v_soc #(
  parameter int          ROM_DEPTH = 4096,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  logic [29:0] iaddr;
  logic [31:0] instr;

  open_risc_v #(.RESET_PC(RESET_PC)) open_risc_v_inst (
    .clk   (clk),
    .rst   (rst),
    .instr (instr),
    .iaddr (iaddr)
  );

  open_risc_v_rom #(.ROM_DEPTH(ROM_DEPTH)) rom_inst (
    .addr (iaddr),
    .data (instr)
  );
endmodule

// File: tb/tb_open_risc_v_soc.sv
// tb_open_risc_v_soc: directed programs with a scoreboard of expected architectural state

module tb_open_risc_v_soc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  open_risc_v_soc dut (.clk(clk), .rst(rst));

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  int          compared = 0;
  int          mismatched = 0;
  event        check_ev;
  exp_t        e;
  logic [31:0] act;

  // monitor: on each snapshot request, pop every expectation and compare against DUT state
  initial forever begin
    @(check_ev);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.idx == 32) act = dut.open_risc_v_inst.pc;
      else act = dut.open_risc_v_inst.regs_inst.regs[e.idx];
      compared++;
      if (act !== e.val) begin
        mismatched++;
        $display("FAIL %s: got %h, required %h", e.name, act, e.val);
      end
    end
  end

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int f3, int rd, int rs1, int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs1, int rs2, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] enc_u(int imm, int rd, int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(imm, rs1, 0, rd, 'h13);
  endfunction

  task automatic put(logic [31:0] w);
    prog.push_back(w);
  endtask

  task automatic expect_reg(string name, int idx, logic [31:0] val);
    exp_t x;
    x.name = name;
    x.idx  = idx;
    x.val  = val;
    sb.push_back(x);
  endtask

  task automatic check();
    ->check_ev;
    #1;
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL monitor_drain: %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // load the program, hold reset for one edge, then release
  task automatic start();
    for (int i = 0; i < 128; i++) dut.rom_inst.rom_mem[i] = 32'h0;
    foreach (prog[i]) dut.rom_inst.rom_mem[i] = prog[i];
    prog.delete();
    rst = 1'b0;
    step(1);
    rst = 1'b1;
  endtask

  initial begin
    // ADD program
    put(addi(27, 0, 5)); put(addi(28, 0, 7)); put(enc_r(0, 0, 29, 27, 28));
    start();
    expect_reg("reset_pc", 32, 32'h0);
    check();
    step(3);
    expect_reg("add_x27", 27, 32'd5);
    expect_reg("add_x28", 28, 32'd7);
    expect_reg("add_x29", 29, 32'd12);
    expect_reg("add_pc", 32, 32'd12);
    check();
    // reset clears registers and pc
    rst = 1'b0;
    step(1);
    expect_reg("rst_x27", 27, 32'h0);
    expect_reg("rst_x29", 29, 32'h0);
    expect_reg("rst_pc", 32, 32'h0);
    check();
    // mid-program reset discards the in-flight ADD, then rerun completes
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    expect_reg("mid_x27", 27, 32'h0);
    expect_reg("mid_x28", 28, 32'h0);
    expect_reg("mid_x29", 29, 32'h0);
    expect_reg("mid_pc", 32, 32'h0);
    check();
    rst = 1'b1;
    step(3);
    expect_reg("rerun_x29", 29, 32'd12);
    expect_reg("rerun_pc", 32, 32'd12);
    check();

    // SUB / SLT / SLTU
    put(addi(26, 0, -1)); put(addi(27, 0, 3)); put(addi(28, 0, 5));
    put(enc_r(32, 0, 29, 27, 28)); put(enc_r(0, 2, 30, 27, 28));
    put(enc_r(0, 3, 26, 28, 27)); put(enc_r(0, 2, 31, 29, 27));
    put(enc_r(0, 3, 25, 27, 29));
    start();
    step(8);
    expect_reg("sub", 29, 32'hFFFF_FFFE);
    expect_reg("slt_3_5", 30, 32'd1);
    expect_reg("sltu_5_3", 26, 32'd0);
    expect_reg("slt_neg", 31, 32'd1);
    expect_reg("sltu_big", 25, 32'd1);
    check();

    // x0 stays zero
    put(addi(29, 0, -1)); put(addi(0, 0, 9)); put(enc_r(0, 0, 29, 0, 0));
    start();
    step(3);
    expect_reg("x0", 0, 32'h0);
    expect_reg("add_x0", 29, 32'h0);
    check();

    // BEQ taken skips one instruction
    put(addi(27, 0, 1)); put(enc_b(8, 27, 27, 0)); put(addi(28, 0, 1)); put(addi(29, 0, 2));
    start();
    step(3);
    expect_reg("beq_x28", 28, 32'h0);
    expect_reg("beq_x29", 29, 32'd2);
    expect_reg("beq_pc", 32, 32'd16);
    check();

    // BNE not taken falls through
    put(addi(27, 0, 1)); put(enc_b(8, 27, 27, 1)); put(addi(28, 0, 1)); put(addi(29, 0, 2));
    start();
    step(4);
    expect_reg("bne_x28", 28, 32'd1);
    expect_reg("bne_x29", 29, 32'd2);
    expect_reg("bne_pc", 32, 32'd16);
    check();

    // JAL then JALR with odd offset
    put(enc_j(8, 27)); put(addi(29, 0, 7)); put(enc_i(1, 27, 0, 28, 'h67));
    start();
    step(1);
    expect_reg("jal_link", 27, 32'd4);
    expect_reg("jal_pc", 32, 32'd8);
    check();
    step(1);
    expect_reg("jalr_link", 28, 32'd12);
    expect_reg("jalr_pc", 32, 32'd4);
    check();
    step(1);
    expect_reg("after_jalr", 29, 32'd7);
    check();

    // shifts, logic ops, LUI/AUIPC, signed/unsigned branches, load as NOP
    put(enc_u('h80000, 1, 'h37)); put(enc_i('h404, 1, 5, 2, 'h13)); put(enc_i(4, 1, 5, 3, 'h13));
    put(addi(4, 0, 33)); put(addi(6, 0, -16)); put(enc_r(0, 1, 5, 6, 4));
    put(enc_r(32, 5, 7, 6, 4)); put(enc_u(1, 8, 'h17)); put(enc_i('hFF, 6, 4, 9, 'h13));
    put(enc_i(-256, 4, 6, 10, 'h13)); put(enc_i('h7F, 6, 7, 11, 'h13)); put(enc_i(-1, 4, 3, 12, 'h13));
    put(enc_i(-15, 6, 2, 13, 'h13)); put(enc_b(8, 6, 4, 4)); put(addi(14, 0, 1));
    put(enc_b(8, 6, 4, 6)); put(enc_b(8, 6, 4, 5)); put(enc_b(8, 6, 4, 7));
    put(addi(15, 0, 1)); put(enc_r(0, 6, 16, 9, 11)); put(enc_r(0, 7, 17, 9, 10));
    put(enc_i(3, 4, 1, 18, 'h13)); put(enc_r(0, 5, 19, 6, 4)); put(enc_r(0, 4, 20, 9, 6));
    put(enc_i(0, 0, 2, 21, 'h03));
    start();
    step(23);
    expect_reg("lui", 1, 32'h8000_0000);
    expect_reg("srai", 2, 32'hF800_0000);
    expect_reg("srli", 3, 32'h0800_0000);
    expect_reg("sll_mod32", 5, 32'hFFFF_FFE0);
    expect_reg("sra_mod32", 7, 32'hFFFF_FFF8);
    expect_reg("auipc", 8, 32'h0000_101C);
    expect_reg("xori", 9, 32'hFFFF_FF0F);
    expect_reg("ori_sext", 10, 32'hFFFF_FF21);
    expect_reg("andi", 11, 32'h0000_0070);
    expect_reg("sltiu", 12, 32'd1);
    expect_reg("slti", 13, 32'd1);
    expect_reg("blt_taken", 14, 32'h0);
    expect_reg("bgeu_taken", 15, 32'h0);
    expect_reg("or", 16, 32'hFFFF_FF7F);
    expect_reg("and", 17, 32'hFFFF_FF01);
    expect_reg("slli", 18, 32'h0000_0108);
    expect_reg("srl", 19, 32'h7FFF_FFF8);
    expect_reg("xor", 20, 32'h0000_00FF);
    expect_reg("load_nop", 21, 32'h0);
    expect_reg("mix_pc", 32, 32'd100);
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
